// File: rtl/seg_sched_pkg.sv
// rtl/seg_sched_pkg.sv - shared types and constants for the display update scheduler
// Purpose: scheduler state encoding, register offsets within the display
//          peripheral, and AHB-Lite encodings used by the scheduler.
// Ports:   none (package).
package seg_sched_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_A_FRAC,
    ST_A_INT,
    ST_A_MODE,
    ST_D_MODE,
    ST_DONE
  } state_t;

  localparam logic [31:0] FRAC_OFS = 32'h0000_0000;
  localparam logic [31:0] INT_OFS  = 32'h0000_0004;
  localparam logic [31:0] MODE_OFS = 32'h0000_0008;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [2:0] HSIZE_WORD    = 3'b010;
  localparam logic [2:0] HBURST_SINGLE = 3'b000;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin pick among requesters
// Purpose: picks the first active request after the last-granted channel,
//          wrapping around; the pointer itself is owned by the caller.
// Ports:   i_req   - request vector
//          i_last  - index of the channel granted last
//          o_grant - one-hot grant
//          o_valid - any request picked
module rr_arbiter #(
  parameter int N_REQ = 4
) (
  input  logic [N_REQ-1:0]         i_req,
  input  logic [$clog2(N_REQ)-1:0] i_last,
  output logic [N_REQ-1:0]         o_grant,
  output logic                     o_valid
);

  always_comb begin
    o_grant = '0;
    o_valid = 1'b0;
    // Channels above the last grant take precedence, then wrap to the rest.
    for (int j = 0; j < N_REQ; j++) begin
      if (!o_valid && i_req[j] && (j > int'(i_last))) begin
        o_grant[j] = 1'b1;
        o_valid    = 1'b1;
      end
    end
    for (int j = 0; j < N_REQ; j++) begin
      if (!o_valid && i_req[j] && (j <= int'(i_last))) begin
        o_grant[j] = 1'b1;
        o_valid    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/seg_display_sched.sv
// rtl/seg_display_sched.sv - round-robin AHB-Lite writer feeding the seven-segment display
// Purpose: grants one requester at a time, captures its fraction/integer/mode
//          triple and writes it to the display's three store registers with
//          three pipelined single write transfers, then enforces a hold time.
// Ports:   HCLK, HRESET       - clock, synchronous active-high reset
//          req/ack/busy       - per-requester handshake, update in progress
//          frac_in/int_in/mode_in - per-requester packed values
//          HADDR..HWDATA      - AHB-Lite master outputs, HREADY input
module seg_display_sched
  import seg_sched_pkg::*;
#(
  parameter int          N_REQ       = 4,
  parameter logic [31:0] BASE_ADDR   = 32'hA000_0000,
  parameter int          HOLD_CYCLES = 1024
) (
  input  logic                HCLK,
  input  logic                HRESET,
  input  logic [N_REQ-1:0]    req,
  input  logic [N_REQ*8-1:0]  frac_in,
  input  logic [N_REQ*12-1:0] int_in,
  input  logic [N_REQ*4-1:0]  mode_in,
  output logic [N_REQ-1:0]    ack,
  output logic                busy,
  output logic [31:0]         HADDR,
  output logic [1:0]          HTRANS,
  output logic                HWRITE,
  output logic [2:0]          HSIZE,
  output logic [2:0]          HBURST,
  output logic [31:0]         HWDATA,
  input  logic                HREADY
);

  localparam int PW = $clog2(N_REQ);
  localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES + 1) : 1;

  state_t           r_state;
  logic [N_REQ-1:0] r_grant;
  logic [PW-1:0]    r_gidx;
  logic [PW-1:0]    r_last;
  logic [HW-1:0]    r_hold;
  logic [7:0]       r_frac;
  logic [11:0]      r_int;
  logic [3:0]       r_mode;
  logic [N_REQ-1:0] r_ack;
  logic             r_busy;
  logic [31:0]      r_haddr;
  logic [1:0]       r_htrans;
  logic             r_hwrite;
  logic [31:0]      r_hwdata;

  logic [N_REQ-1:0] w_grant;
  logic             w_valid;
  logic [PW-1:0]    w_idx;
  logic [7:0]       w_frac;
  logic [11:0]      w_int;
  logic [3:0]       w_mode;
  logic             w_hold_ok;

  rr_arbiter #(.N_REQ(N_REQ)) u_arb (
    .i_req   (req),
    .i_last  (r_last),
    .o_grant (w_grant),
    .o_valid (w_valid)
  );

  always_comb begin
    w_idx  = '0;
    w_frac = '0;
    w_int  = '0;
    w_mode = '0;
    for (int j = 0; j < N_REQ; j++) begin
      if (w_grant[j]) begin
        w_idx  = PW'(j);
        w_frac = frac_in[j*8 +: 8];
        w_int  = int_in[j*12 +: 12];
        w_mode = mode_in[j*4 +: 4];
      end
    end
  end

  // The counter reaches zero on the same edge that issues the grant, so the
  // next address phase lands exactly HOLD_CYCLES+1 cycles after the ack.
  assign w_hold_ok = (r_hold <= HW'(1));

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      r_state  <= ST_IDLE;
      r_grant  <= '0;
      r_gidx   <= '0;
      r_last   <= PW'(N_REQ - 1);
      r_hold   <= '0;
      r_frac   <= '0;
      r_int    <= '0;
      r_mode   <= '0;
      r_ack    <= '0;
      r_busy   <= 1'b0;
      r_haddr  <= '0;
      r_htrans <= HTRANS_IDLE;
      r_hwrite <= 1'b0;
      r_hwdata <= '0;
    end else begin
      r_ack <= '0;
      if (r_hold != '0) r_hold <= r_hold - 1'b1;
      case (r_state)
        ST_IDLE: begin
          if (w_hold_ok && w_valid) begin
            r_state  <= ST_A_FRAC;
            r_grant  <= w_grant;
            r_gidx   <= w_idx;
            r_frac   <= w_frac;
            r_int    <= w_int;
            r_mode   <= w_mode;
            r_busy   <= 1'b1;
            r_htrans <= HTRANS_NONSEQ;
            r_hwrite <= 1'b1;
            r_haddr  <= BASE_ADDR + FRAC_OFS;
            r_hwdata <= '0;
          end
        end
        ST_A_FRAC: begin
          if (HREADY) begin
            r_state  <= ST_A_INT;
            r_haddr  <= BASE_ADDR + INT_OFS;
            r_hwdata <= {24'b0, r_frac};
          end
        end
        ST_A_INT: begin
          if (HREADY) begin
            r_state  <= ST_A_MODE;
            r_haddr  <= BASE_ADDR + MODE_OFS;
            r_hwdata <= {20'b0, r_int};
          end
        end
        ST_A_MODE: begin
          if (HREADY) begin
            r_state  <= ST_D_MODE;
            r_htrans <= HTRANS_IDLE;
            r_hwrite <= 1'b0;
            r_haddr  <= '0;
            r_hwdata <= {28'b0, r_mode};
          end
        end
        ST_D_MODE: begin
          if (HREADY) begin
            r_state  <= ST_DONE;
            r_hwdata <= '0;
            r_ack    <= r_grant;
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
          r_grant <= '0;
          r_last  <= r_gidx;
          r_hold  <= HW'(HOLD_CYCLES);
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign ack    = r_ack;
  assign busy   = r_busy;
  assign HADDR  = r_haddr;
  assign HTRANS = r_htrans;
  assign HWRITE = r_hwrite;
  assign HWDATA = r_hwdata;
  assign HSIZE  = HSIZE_WORD;
  assign HBURST = HBURST_SINGLE;

endmodule

// File: tb/tb_seg_display_sched.sv
// tb/tb_seg_display_sched.sv - self-checking bench for the display update scheduler
module tb_seg_display_sched;

  localparam logic [31:0] BASE = 32'hA000_0000;

  logic HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  logic        HRESET = 1'b1;
  logic        HREADY = 1'b1;
  logic [3:0]  req = '0;
  logic [7:0]  frac_d [4];
  logic [11:0] int_d  [4];
  logic [3:0]  mode_d [4];
  logic [31:0] frac_bus;
  logic [47:0] int_bus;
  logic [15:0] mode_bus;

  always_comb begin
    frac_bus = '0;
    int_bus  = '0;
    mode_bus = '0;
    for (int i = 0; i < 4; i++) begin
      frac_bus[i*8 +: 8]  = frac_d[i];
      int_bus[i*12 +: 12] = int_d[i];
      mode_bus[i*4 +: 4]  = mode_d[i];
    end
  end

  logic [3:0]  a_ack, b_ack;
  logic        a_busy, b_busy, a_hwrite, b_hwrite;
  logic [31:0] a_haddr, b_haddr, a_hwdata, b_hwdata;
  logic [1:0]  a_htrans, b_htrans;
  logic [2:0]  a_hsize, b_hsize, a_hburst, b_hburst;

  seg_display_sched #(.N_REQ(4), .BASE_ADDR(BASE), .HOLD_CYCLES(0)) u_h0 (
    .HCLK(HCLK), .HRESET(HRESET), .req(req), .frac_in(frac_bus), .int_in(int_bus),
    .mode_in(mode_bus), .ack(a_ack), .busy(a_busy), .HADDR(a_haddr), .HTRANS(a_htrans),
    .HWRITE(a_hwrite), .HSIZE(a_hsize), .HBURST(a_hburst), .HWDATA(a_hwdata), .HREADY(HREADY)
  );

  seg_display_sched #(.N_REQ(4), .BASE_ADDR(BASE), .HOLD_CYCLES(10)) u_h10 (
    .HCLK(HCLK), .HRESET(HRESET), .req(req), .frac_in(frac_bus), .int_in(int_bus),
    .mode_in(mode_bus), .ack(b_ack), .busy(b_busy), .HADDR(b_haddr), .HTRANS(b_htrans),
    .HWRITE(b_hwrite), .HSIZE(b_hsize), .HBURST(b_hburst), .HWDATA(b_hwdata), .HREADY(HREADY)
  );

  int n_pass = 0;
  int n_total = 0;
  int cyc = 0;
  int hmode = 0;
  int stall_lo = 0;
  int model_last = 3;
  bit gen_en = 0, model_en = 0, use_b = 0;
  bit pend_v = 0, busy_prev = 0;
  logic [31:0] pend_a = '0;
  logic [3:0]  drop = '0, req_prev = '0;

  logic [31:0] wr_a_q[$], wr_d_q[$], exp_a_q[$], exp_d_q[$];
  int ack_ch_q[$], ack_cyc_q[$], fr_cyc_q[$], exp_ch_q[$];

  task automatic push_exp_update(int ch);
    exp_a_q.push_back(BASE);         exp_d_q.push_back({24'b0, frac_d[ch]});
    exp_a_q.push_back(BASE + 32'd4); exp_d_q.push_back({20'b0, int_d[ch]});
    exp_a_q.push_back(BASE + 32'd8); exp_d_q.push_back({28'b0, mode_d[ch]});
  endtask

  // Reference round-robin: next requesting channel after the last one served.
  task automatic model_grant(logic [3:0] rq);
    bit found = 0;
    int c;
    for (int i = 1; i <= 4; i++) begin
      c = (model_last + i) % 4;
      if (!found && rq[c]) begin
        found = 1;
        model_last = c;
        exp_ch_q.push_back(c);
        push_exp_update(c);
      end
    end
    n_total++;
    if (!found) $display("FAIL model_grant got grant with req=%b exp no grant", rq);
    else n_pass++;
  endtask

  task automatic tick();
    @(posedge HCLK);
    cyc++;
    #1;
    req_prev = req;
    req = req & ~drop;
    case (hmode)
      1:       HREADY = ($urandom_range(0, 3) != 0);
      2:       HREADY = !(cyc >= stall_lo && cyc < stall_lo + 3);
      default: HREADY = 1'b1;
    endcase
    if (gen_en) begin
      for (int ch = 0; ch < 4; ch++) begin
        if (!req[ch] && $urandom_range(0, 7) == 0) begin
          frac_d[ch] = 8'($urandom_range(0, 255));
          int_d[ch]  = 12'($urandom_range(0, 4095));
          mode_d[ch] = 4'($urandom_range(0, 15));
          req[ch] = 1'b1;
        end
      end
    end
    @(negedge HCLK);
    if (pend_v && HREADY) begin
      wr_a_q.push_back(pend_a);
      wr_d_q.push_back(a_hwdata);
    end
    if (HREADY) begin
      pend_v = (a_htrans == 2'b10);
      pend_a = a_haddr;
    end
    if (a_busy && !busy_prev) begin
      fr_cyc_q.push_back(cyc);
      if (model_en) model_grant(req_prev);
    end
    busy_prev = a_busy;
    for (int ch = 0; ch < 4; ch++) begin
      if (a_ack[ch]) begin
        ack_ch_q.push_back(ch);
        ack_cyc_q.push_back(cyc);
      end
    end
    drop = use_b ? b_ack : a_ack;
  endtask

  task automatic do_reset();
    HRESET = 1'b1; req = '0; drop = '0; hmode = 0;
    gen_en = 0; model_en = 0; use_b = 0;
    tick(); tick();
    HRESET = 1'b0; pend_v = 0; busy_prev = 0; model_last = 3; drop = '0;
  endtask

  task automatic test_reset();
    HRESET = 1'b1; req = 4'hF;
    tick(); tick(); tick();
    n_total += 6;
    if (a_htrans !== 2'b00) $display("FAIL reset_htrans got %b exp 00", a_htrans); else n_pass++;
    if (a_haddr !== 32'h0) $display("FAIL reset_haddr got %h exp 0", a_haddr); else n_pass++;
    if (a_hwdata !== 32'h0) $display("FAIL reset_hwdata got %h exp 0", a_hwdata); else n_pass++;
    if ({a_ack, a_busy} !== 5'b0) $display("FAIL reset_ack_busy got %b exp 0", {a_ack, a_busy}); else n_pass++;
    if ({a_hwrite, a_hsize, a_hburst} !== 7'b0_010_000)
      $display("FAIL reset_ctrl got %b exp 0010000", {a_hwrite, a_hsize, a_hburst}); else n_pass++;
    if ({b_htrans, b_haddr, b_hwdata, b_ack, b_busy, b_hwrite} !== 72'h0)
      $display("FAIL reset_h10 got %h exp 0", {b_htrans, b_haddr, b_hwdata, b_ack, b_busy, b_hwrite}); else n_pass++;
    req = '0;
  endtask

  task automatic test_single();
    logic [1:0]  e_tr [6] = '{2'b10, 2'b10, 2'b10, 2'b00, 2'b00, 2'b00};
    logic [31:0] e_ad [6] = '{BASE, BASE + 32'd4, BASE + 32'd8, 32'h0, 32'h0, 32'h0};
    logic [31:0] e_wd [6] = '{32'h0, 32'h25, 32'h012, 32'hA, 32'h0, 32'h0};
    logic [3:0]  e_ak [6] = '{4'h0, 4'h0, 4'h0, 4'h0, 4'h2, 4'h0};
    logic        e_bz [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    int w0, e0;
    do_reset();
    frac_d[1] = 8'h25; int_d[1] = 12'h012; mode_d[1] = 4'hA;
    w0 = wr_a_q.size(); e0 = exp_a_q.size();
    push_exp_update(1);
    req[1] = 1'b1;
    for (int j = 0; j < 6; j++) begin
      tick();
      n_total += 4;
      if (a_htrans !== e_tr[j]) $display("FAIL single_htrans[%0d] got %b exp %b", j, a_htrans, e_tr[j]); else n_pass++;
      if (a_haddr !== e_ad[j]) $display("FAIL single_haddr[%0d] got %h exp %h", j, a_haddr, e_ad[j]); else n_pass++;
      if (a_ack !== e_ak[j]) $display("FAIL single_ack[%0d] got %b exp %b", j, a_ack, e_ak[j]); else n_pass++;
      if (a_busy !== e_bz[j]) $display("FAIL single_busy[%0d] got %b exp %b", j, a_busy, e_bz[j]); else n_pass++;
      if (j >= 1 && j <= 3) begin
        n_total++;
        if (a_hwdata !== e_wd[j]) $display("FAIL single_hwdata[%0d] got %h exp %h", j, a_hwdata, e_wd[j]); else n_pass++;
      end
    end
    n_total++;
    if (wr_a_q.size() - w0 !== 3) $display("FAIL single_nwrites got %0d exp 3", wr_a_q.size() - w0); else n_pass++;
    for (int i = 0; i < 3 && w0 + i < wr_a_q.size(); i++) begin
      n_total++;
      if ({wr_a_q[w0+i], wr_d_q[w0+i]} !== {exp_a_q[e0+i], exp_d_q[e0+i]})
        $display("FAIL single_write[%0d] got %h<-%h exp %h<-%h", i, wr_a_q[w0+i], wr_d_q[w0+i], exp_a_q[e0+i], exp_d_q[e0+i]);
      else n_pass++;
    end
  endtask

  task automatic test_round_robin();
    int k, a0, f0, w0, e0;
    do_reset();
    for (int ch = 0; ch < 4; ch++) begin
      frac_d[ch] = 8'($urandom_range(0, 255));
      int_d[ch]  = 12'($urandom_range(0, 4095));
      mode_d[ch] = 4'($urandom_range(0, 15));
    end
    a0 = ack_ch_q.size(); f0 = fr_cyc_q.size(); w0 = wr_a_q.size(); e0 = exp_a_q.size();
    for (int ch = 0; ch < 4; ch++) push_exp_update(ch);
    k = cyc;
    req = 4'hF;
    for (int j = 0; j < 28; j++) tick();
    n_total += 2;
    if (ack_ch_q.size() - a0 !== 4) $display("FAIL rr_nack got %0d exp 4", ack_ch_q.size() - a0); else n_pass++;
    if (wr_a_q.size() - w0 !== 12) $display("FAIL rr_nwrites got %0d exp 12", wr_a_q.size() - w0); else n_pass++;
    for (int i = 0; i < 4 && a0 + i < ack_ch_q.size() && f0 + i < fr_cyc_q.size(); i++) begin
      n_total += 3;
      if (ack_ch_q[a0+i] !== i) $display("FAIL rr_order[%0d] got %0d exp %0d", i, ack_ch_q[a0+i], i); else n_pass++;
      if (ack_cyc_q[a0+i] !== k + 5 + 6*i) $display("FAIL rr_ackcyc[%0d] got %0d exp %0d", i, ack_cyc_q[a0+i], k + 5 + 6*i); else n_pass++;
      if (fr_cyc_q[f0+i] !== k + 1 + 6*i) $display("FAIL rr_fraccyc[%0d] got %0d exp %0d", i, fr_cyc_q[f0+i], k + 1 + 6*i); else n_pass++;
    end
    for (int i = 0; i < 12 && w0 + i < wr_a_q.size(); i++) begin
      n_total++;
      if ({wr_a_q[w0+i], wr_d_q[w0+i]} !== {exp_a_q[e0+i], exp_d_q[e0+i]})
        $display("FAIL rr_write[%0d] got %h<-%h exp %h<-%h", i, wr_a_q[w0+i], wr_d_q[w0+i], exp_a_q[e0+i], exp_d_q[e0+i]);
      else n_pass++;
    end
  endtask

  task automatic test_stall();
    int k, a0, w0, e0;
    do_reset();
    frac_d[3] = 8'($urandom_range(0, 255));
    int_d[3]  = 12'($urandom_range(0, 4095));
    mode_d[3] = 4'($urandom_range(0, 15));
    a0 = ack_ch_q.size(); w0 = wr_a_q.size(); e0 = exp_a_q.size();
    push_exp_update(3);
    k = cyc;
    stall_lo = k + 2;
    hmode = 2;
    req[3] = 1'b1;
    for (int j = 0; j < 10; j++) begin
      tick();
      if (cyc >= k + 2 && cyc <= k + 5) begin
        n_total += 2;
        if ({a_htrans, a_haddr} !== {2'b10, BASE + 32'd4})
          $display("FAIL stall_addr@%0d got %b/%h exp 10/%h", cyc - k, a_htrans, a_haddr, BASE + 32'd4); else n_pass++;
        if (a_hwdata !== {24'b0, frac_d[3]})
          $display("FAIL stall_hwdata@%0d got %h exp %h", cyc - k, a_hwdata, {24'b0, frac_d[3]}); else n_pass++;
      end
    end
    hmode = 0;
    n_total += 2;
    if (ack_ch_q.size() - a0 !== 1) $display("FAIL stall_nack got %0d exp 1", ack_ch_q.size() - a0); else n_pass++;
    if (ack_cyc_q.size() > a0 && ack_cyc_q[a0] !== k + 8)
      $display("FAIL stall_ackcyc got %0d exp %0d", ack_cyc_q[a0] - k, 8); else n_pass++;
    for (int i = 0; i < 3; i++) begin
      n_total++;
      if (w0 + i >= wr_a_q.size()) $display("FAIL stall_write[%0d] got none exp %h", i, exp_a_q[e0+i]);
      else if ({wr_a_q[w0+i], wr_d_q[w0+i]} !== {exp_a_q[e0+i], exp_d_q[e0+i]})
        $display("FAIL stall_write[%0d] got %h<-%h exp %h<-%h", i, wr_a_q[w0+i], wr_d_q[w0+i], exp_a_q[e0+i], exp_d_q[e0+i]);
      else n_pass++;
    end
  endtask

  task automatic test_hold();
    int k, ack0_c, fr1_c, ack1_c;
    do_reset();
    use_b = 1;
    for (int ch = 0; ch < 2; ch++) begin
      frac_d[ch] = 8'($urandom_range(0, 255));
      int_d[ch]  = 12'($urandom_range(0, 4095));
      mode_d[ch] = 4'($urandom_range(0, 15));
    end
    ack0_c = -1; fr1_c = -1; ack1_c = -1;
    k = cyc;
    req = 4'b0011;
    for (int j = 0; j < 40; j++) begin
      tick();
      if (b_ack[0] && ack0_c < 0) ack0_c = cyc;
      if (ack0_c >= 0 && fr1_c < 0 && b_htrans == 2'b10 && b_haddr == BASE) fr1_c = cyc;
      if (b_ack[1] && ack1_c < 0) ack1_c = cyc;
    end
    use_b = 0;
    n_total += 3;
    if (ack0_c !== k + 5) $display("FAIL hold_ack0 got %0d exp %0d", ack0_c - k, 5); else n_pass++;
    if (fr1_c - ack0_c !== 11) $display("FAIL hold_gap got %0d exp 11", fr1_c - ack0_c); else n_pass++;
    if (ack1_c - fr1_c !== 4) $display("FAIL hold_ack1 got %0d exp 4", ack1_c - fr1_c); else n_pass++;
  endtask

  task automatic test_capture();
    int k, a0, w0, e0;
    do_reset();
    frac_d[2] = 8'($urandom_range(0, 255));
    int_d[2]  = 12'($urandom_range(0, 4095));
    mode_d[2] = 4'($urandom_range(0, 15));
    a0 = ack_ch_q.size(); w0 = wr_a_q.size(); e0 = exp_a_q.size();
    push_exp_update(2);
    k = cyc;
    req[2] = 1'b1;
    tick();
    frac_d[2] = ~frac_d[2]; int_d[2] = ~int_d[2]; mode_d[2] = ~mode_d[2];
    for (int j = 0; j < 7; j++) tick();
    n_total++;
    if (ack_ch_q.size() - a0 !== 1 || ack_cyc_q[a0] !== k + 5)
      $display("FAIL capture_ack got n=%0d exp n=1 at +5", ack_ch_q.size() - a0); else n_pass++;
    for (int i = 0; i < 3; i++) begin
      n_total++;
      if (w0 + i >= wr_a_q.size()) $display("FAIL capture_write[%0d] got none exp %h", i, exp_d_q[e0+i]);
      else if ({wr_a_q[w0+i], wr_d_q[w0+i]} !== {exp_a_q[e0+i], exp_d_q[e0+i]})
        $display("FAIL capture_write[%0d] got %h<-%h exp %h<-%h", i, wr_a_q[w0+i], wr_d_q[w0+i], exp_a_q[e0+i], exp_d_q[e0+i]);
      else n_pass++;
    end
  endtask

  task automatic test_reset_mid();
    int k, a0, w0, e0;
    do_reset();
    frac_d[3] = 8'($urandom_range(0, 255));
    int_d[3]  = 12'($urandom_range(0, 4095));
    mode_d[3] = 4'($urandom_range(0, 15));
    k = cyc;
    req[3] = 1'b1;
    tick(); tick(); tick();
    n_total++;
    if (a_haddr !== BASE + 32'd8) $display("FAIL rmid_amode got %h exp %h", a_haddr, BASE + 32'd8); else n_pass++;
    HRESET = 1'b1;
    a0 = ack_ch_q.size();
    tick();
    n_total += 3;
    if (a_htrans !== 2'b00) $display("FAIL rmid_htrans got %b exp 00", a_htrans); else n_pass++;
    if (a_busy !== 1'b0) $display("FAIL rmid_busy got %b exp 0", a_busy); else n_pass++;
    if (a_ack !== 4'h0) $display("FAIL rmid_ack got %b exp 0", a_ack); else n_pass++;
    HRESET = 1'b0;
    w0 = wr_a_q.size(); e0 = exp_a_q.size();
    push_exp_update(3);
    for (int j = 0; j < 10; j++) tick();
    n_total++;
    if (ack_ch_q.size() - a0 !== 1 || ack_cyc_q[a0] !== k + 9)
      $display("FAIL rmid_reack got n=%0d exp n=1 at +9", ack_ch_q.size() - a0); else n_pass++;
    for (int i = 0; i < 3; i++) begin
      n_total++;
      if (w0 + i >= wr_a_q.size()) $display("FAIL rmid_write[%0d] got none exp %h", i, exp_d_q[e0+i]);
      else if ({wr_a_q[w0+i], wr_d_q[w0+i]} !== {exp_a_q[e0+i], exp_d_q[e0+i]})
        $display("FAIL rmid_write[%0d] got %h<-%h exp %h<-%h", i, wr_a_q[w0+i], wr_d_q[w0+i], exp_a_q[e0+i], exp_d_q[e0+i]);
      else n_pass++;
    end
  endtask

  task automatic test_random();
    int a0, w0, e0, x0, n;
    bit drained = 0;
    do_reset();
    a0 = ack_ch_q.size(); w0 = wr_a_q.size(); e0 = exp_a_q.size(); x0 = exp_ch_q.size();
    model_en = 1; gen_en = 1; hmode = 1;
    for (int j = 0; j < 400; j++) tick();
    gen_en = 0;
    for (int j = 0; j < 300 && !drained; j++) begin
      tick();
      if (req == 4'h0 && !a_busy) drained = 1;
    end
    model_en = 0; hmode = 0;
    n_total += 3;
    if (!drained) $display("FAIL rand_drain got busy exp idle within 300 cycles"); else n_pass++;
    n = exp_ch_q.size() - x0;
    if (ack_ch_q.size() - a0 !== n) $display("FAIL rand_nack got %0d exp %0d", ack_ch_q.size() - a0, n); else n_pass++;
    if (wr_a_q.size() - w0 !== 3*n) $display("FAIL rand_nwrites got %0d exp %0d", wr_a_q.size() - w0, 3*n); else n_pass++;
    for (int i = 0; i < n && a0 + i < ack_ch_q.size(); i++) begin
      n_total++;
      if (ack_ch_q[a0+i] !== exp_ch_q[x0+i])
        $display("FAIL rand_order[%0d] got %0d exp %0d", i, ack_ch_q[a0+i], exp_ch_q[x0+i]); else n_pass++;
    end
    for (int i = 0; i < 3*n && w0 + i < wr_a_q.size(); i++) begin
      n_total++;
      if ({wr_a_q[w0+i], wr_d_q[w0+i]} !== {exp_a_q[e0+i], exp_d_q[e0+i]})
        $display("FAIL rand_write[%0d] got %h<-%h exp %h<-%h", i, wr_a_q[w0+i], wr_d_q[w0+i], exp_a_q[e0+i], exp_d_q[e0+i]);
      else n_pass++;
    end
  endtask

  initial begin
    for (int i = 0; i < 4; i++) begin
      frac_d[i] = '0; int_d[i] = '0; mode_d[i] = '0;
    end
    test_reset();
    test_single();
    test_round_robin();
    test_stall();
    test_hold();
    test_capture();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
